// File: rtl/skew_delay_buf.sv
// skew_delay_buf: multi-lane delay line with per-lane programmable tap (1..MAX_DELAY enabled cycles),
// used to skew operands into and de-skew results out of the systolic array.
module skew_delay_buf #(
  parameter int CHANNELS = 8,
  parameter int BITS = 64,
  parameter int MAX_DELAY = 8,
  localparam int DW = $clog2(MAX_DELAY + 1),
  localparam int LW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [CHANNELS*BITS-1:0] d,
  input  logic [CHANNELS-1:0]      d_valid,
  input  logic                     cfg_we,
  input  logic [LW-1:0]            cfg_lane,
  input  logic [DW-1:0]            cfg_delay,
  output logic [CHANNELS*BITS-1:0] q,
  output logic [CHANNELS-1:0]      q_valid,
  output logic                     busy,
  output logic [CHANNELS*DW-1:0]   delay_o
);
  logic [DW-1:0] cfg_val;
  logic cfg_ok;
  logic [CHANNELS-1:0] lane_busy;
  assign cfg_ok = cfg_we && (32'(cfg_lane) < CHANNELS);
  assign cfg_val = cfg_delay == '0 ? DW'(1) : 32'(cfg_delay) > MAX_DELAY ? DW'(MAX_DELAY) : cfg_delay;
  assign busy = |lane_busy;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic [BITS-1:0] sd [MAX_DELAY];
    logic [MAX_DELAY-1:0] sv;
    logic [DW-1:0] dly;
    logic [BITS-1:0] tap_d;
    logic tap_v;
    logic hit;
    assign hit = cfg_ok && cfg_lane == LW'(i);
    always_ff @(posedge clk) begin
      if (rst) begin
        sv <= '0;
        for (int k = 0; k < MAX_DELAY; k++) sd[k] <= '0;
        dly <= DW'(i + 1 > MAX_DELAY ? MAX_DELAY : i + 1);
      end else begin
        if (hit) dly <= cfg_val;
        // a moved tap would otherwise expose stale or repeated samples
        if (clr || hit) begin
          sv <= '0;
          for (int k = 0; k < MAX_DELAY; k++) sd[k] <= '0;
        end else if (en) begin
          sv[0] <= d_valid[i];
          sd[0] <= d[i*BITS +: BITS];
          for (int k = 1; k < MAX_DELAY; k++) begin
            sv[k] <= sv[k-1];
            sd[k] <= sd[k-1];
          end
        end
      end
    end
    always_comb begin
      tap_d = '0;
      tap_v = 1'b0;
      for (int k = 0; k < MAX_DELAY; k++) begin
        tap_d = dly == DW'(k + 1) ? sd[k] : tap_d;
        tap_v = dly == DW'(k + 1) ? sv[k] : tap_v;
      end
    end
    assign q[i*BITS +: BITS] = tap_d;
    assign q_valid[i] = tap_v;
    assign delay_o[i*DW +: DW] = dly;
    assign lane_busy[i] = |sv;
  end
endmodule

// File: tb/tb_skew_delay_buf.sv
// tb_skew_delay_buf: scoreboard bench; each enabled edge pushes the driven lane words,
// and each lane's output is compared with the entry its current delay selects.
module tb_skew_delay_buf;
  localparam int C = 8, B = 64, M = 8, DW = 4;
  logic clk = 0, rst = 0, en = 0, clr = 0, cfg_we = 0;
  logic [C*B-1:0] d = '0, q;
  logic [C-1:0] d_valid = '0, q_valid;
  logic [2:0] cfg_lane = '0;
  logic [DW-1:0] cfg_delay = '0;
  logic busy;
  logic [C*DW-1:0] delay_o;
  logic en_b = 0, cfg_we_b = 0, busy_b;
  logic [23:0] d_b = '0, q_b;
  logic [2:0] d_valid_b = '0, q_valid_b, cfg_delay_b = '0;
  logic [1:0] cfg_lane_b = '0;
  logic [8:0] delay_o_b;
  int checks = 0, failures = 0, t = 0;
  logic [C*B+C-1:0] sb [$];
  int exp_dly [C];

  skew_delay_buf dut (.clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_delay(cfg_delay), .q(q), .q_valid(q_valid),
    .busy(busy), .delay_o(delay_o));
  skew_delay_buf #(.CHANNELS(3), .BITS(8), .MAX_DELAY(4)) dut_b (.clk(clk), .rst(rst), .en(en_b),
    .clr(clr), .d(d_b), .d_valid(d_valid_b), .cfg_we(cfg_we_b), .cfg_lane(cfg_lane_b),
    .cfg_delay(cfg_delay_b), .q(q_b), .q_valid(q_valid_b), .busy(busy_b), .delay_o(delay_o_b));

  always #5 clk = ~clk;

  function automatic int clamp(int v);
    return v == 0 ? 1 : v > M ? M : v;
  endfunction
  function automatic logic [B:0] exp_lane(int i);
    logic [C*B+C-1:0] e;
    if (sb.size() < exp_dly[i]) return '0;
    e = sb[sb.size() - exp_dly[i]];
    return {e[C*B+i], e[i*B +: B]};
  endfunction
  function automatic logic exp_busy();
    logic b;
    logic [C*B+C-1:0] e;
    b = 1'b0;
    foreach (sb[j]) begin
      e = sb[j];
      b |= |e[C*B +: C];
    end
    return b;
  endfunction
  function automatic logic [C*DW-1:0] exp_delays();
    logic [C*DW-1:0] r;
    for (int i = 0; i < C; i++) r[i*DW +: DW] = DW'(exp_dly[i]);
    return r;
  endfunction

  task automatic drive(int n);
    for (int i = 0; i < C; i++) d[i*B +: B] = {32'(i), 32'(32'h100 + n)};
    d_valid = '1;
  endtask

  task automatic tick();
    logic [C*B+C-1:0] e;
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < C; i++) exp_dly[i] = clamp(i + 1);
    end else begin
      if (cfg_we) exp_dly[cfg_lane] = clamp(int'(cfg_delay));
      if (clr) sb.delete();
      else begin
        if (en) sb.push_back({d_valid, d});
        if (cfg_we)
          foreach (sb[j]) begin
            e = sb[j];
            e[C*B + cfg_lane] = 1'b0;
            e[cfg_lane*B +: B] = '0;
            sb[j] = e;
          end
      end
      while (sb.size() > M) void'(sb.pop_front());
    end
  endtask

  task automatic stream(int n, string name);
    logic [B:0] e;
    repeat (n) begin
      drive(t);
      en = 1;
      tick();
      t++;
      for (int i = 0; i < C; i++) begin
        e = exp_lane(i);
        checks++;
        if (q_valid[i] !== e[B] || (e[B] && q[i*B +: B] !== e[B-1:0])) begin
          failures++;
          $display("FAIL %s lane%0d: got v=%b d=%h want v=%b d=%h", name, i, q_valid[i], q[i*B +: B], e[B], e[B-1:0]);
        end
      end
      checks++;
      if (busy !== exp_busy()) begin
        failures++;
        $display("FAIL %s busy: got %b want %b", name, busy, exp_busy());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 1; clr = 0; cfg_we = 0; drive(77);
    tick();
    rst = 0; en = 0;
    checks += 4;
    if (q !== '0) begin failures++; $display("FAIL reset_q: got %h want 0", q); end
    if (q_valid !== '0) begin failures++; $display("FAIL reset_qv: got %b want 0", q_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (delay_o !== 32'h87654321) begin failures++; $display("FAIL reset_delay: got %h want 87654321", delay_o); end
  endtask

  task automatic test_skew();
    logic [C-1:0] want_v;
    logic [B-1:0] want_d;
    for (int n = 0; n < 12; n++) begin
      stream(1, "skew");
      if (n < C) begin
        want_v = C'((1 << (n + 1)) - 1);
        want_d = {32'(n), 32'h100};
        checks += 2;
        if (q_valid !== want_v) begin failures++; $display("FAIL skew_first_v n=%0d: got %b want %b", n, q_valid, want_v); end
        if (q[n*B +: B] !== want_d) begin failures++; $display("FAIL skew_first_d lane%0d: got %h want %h", n, q[n*B +: B], want_d); end
      end
    end
  endtask

  task automatic test_stall();
    logic [C*B-1:0] hold;
    logic [C-1:0] hv;
    hold = q; hv = q_valid;
    en = 0; drive(999);
    repeat (3) begin
      tick();
      checks += 2;
      if (q !== hold) begin failures++; $display("FAIL stall_q: got %h want %h", q[4*B-1:3*B], hold[4*B-1:3*B]); end
      if (q_valid !== hv) begin failures++; $display("FAIL stall_qv: got %b want %b", q_valid, hv); end
    end
    stream(6, "stall_resume");
  endtask

  task automatic test_reprogram();
    drive(t); en = 1; cfg_we = 1; cfg_lane = 2; cfg_delay = 0;
    tick(); t++; cfg_we = 0;
    checks += 2;
    if (delay_o[2*DW +: DW] !== 4'd1) begin failures++; $display("FAIL clamp_zero: got %0d want 1", delay_o[2*DW +: DW]); end
    if (q_valid[2] !== 1'b0) begin failures++; $display("FAIL reprog_flush0: got %b want 0", q_valid[2]); end
    stream(3, "reprog1");
    drive(t); cfg_we = 1; cfg_delay = 9;
    tick(); t++; cfg_we = 0;
    checks += 3;
    if (delay_o[2*DW +: DW] !== 4'd8) begin failures++; $display("FAIL clamp_max: got %0d want 8", delay_o[2*DW +: DW]); end
    if (q_valid[2] !== 1'b0) begin failures++; $display("FAIL reprog_flush8: got %b want 0", q_valid[2]); end
    if (delay_o !== exp_delays()) begin failures++; $display("FAIL reprog_delays: got %h want %h", delay_o, exp_delays()); end
    stream(10, "reprog8");
  endtask

  task automatic test_cfg_en();
    logic [C-1:0] want;
    drive(t); en = 1; cfg_we = 1; cfg_lane = 5; cfg_delay = 3;
    tick(); t++; cfg_we = 0;
    want = '1; want[5] = 1'b0;
    checks += 3;
    if (q_valid !== want) begin failures++; $display("FAIL cfg_en_qv: got %b want %b", q_valid, want); end
    if (q[B-1:0] !== {32'd0, 32'(32'h100 + t - 1)}) begin failures++; $display("FAIL cfg_en_lane0: got %h want %h", q[B-1:0], {32'd0, 32'(32'h100 + t - 1)}); end
    if (delay_o[5*DW +: DW] !== 4'd3) begin failures++; $display("FAIL cfg_en_delay: got %0d want 3", delay_o[5*DW +: DW]); end
    stream(6, "cfg_en");
  endtask

  task automatic test_clr();
    logic [C*DW-1:0] keep;
    keep = delay_o;
    drive(t); en = 1; clr = 1;
    tick(); clr = 0;
    checks += 3;
    if (q_valid !== '0) begin failures++; $display("FAIL clr_qv: got %b want 0", q_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL clr_busy: got %b want 0", busy); end
    if (delay_o !== keep) begin failures++; $display("FAIL clr_delay: got %h want %h", delay_o, keep); end
    stream(10, "post_clr");
  endtask

  task automatic test_rst_mid();
    drive(t); en = 1; cfg_we = 1; cfg_lane = 0; cfg_delay = 7;
    tick(); t++; cfg_we = 0;
    stream(3, "pre_rst");
    drive(t); rst = 1; clr = 1; cfg_we = 1; cfg_lane = 1; cfg_delay = 3;
    tick();
    rst = 0; clr = 0; cfg_we = 0;
    checks += 4;
    if (delay_o !== 32'h87654321) begin failures++; $display("FAIL rst_mid_delay: got %h want 87654321", delay_o); end
    if (q !== '0) begin failures++; $display("FAIL rst_mid_q: got %h want 0", q); end
    if (q_valid !== '0) begin failures++; $display("FAIL rst_mid_qv: got %b want 0", q_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    stream(9, "post_rst");
  endtask

  task automatic test_oob();
    en = 0;
    checks++;
    if (delay_o_b !== {3'd3, 3'd2, 3'd1}) begin failures++; $display("FAIL oob_reset: got %h want %h", delay_o_b, {3'd3, 3'd2, 3'd1}); end
    cfg_we_b = 1; cfg_lane_b = 3; cfg_delay_b = 2;
    tick();
    checks++;
    if (delay_o_b !== {3'd3, 3'd2, 3'd1}) begin failures++; $display("FAIL oob_lane: got %h want %h", delay_o_b, {3'd3, 3'd2, 3'd1}); end
    cfg_lane_b = 2; cfg_delay_b = 7;
    tick();
    cfg_lane_b = 1; cfg_delay_b = 0;
    tick();
    cfg_we_b = 0;
    checks++;
    if (delay_o_b !== {3'd4, 3'd1, 3'd1}) begin failures++; $display("FAIL oob_clamp: got %h want %h", delay_o_b, {3'd4, 3'd1, 3'd1}); end
  endtask

  initial begin
    test_reset();
    test_skew();
    test_stall();
    test_reprogram();
    test_cfg_en();
    test_clr();
    test_rst_mid();
    test_oob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
